// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs loads/stores on a req/ack data port with lane
// steering, load extension, misalignment/illegal-op detection and a bus timeout.
module mem_access_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3_in,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_out,
  output logic            reg_write,
  output logic            out_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic            ld_q, ld_d;

  logic            in_ready_d, out_valid_d, reg_write_d, out_err_d;
  logic            mem_req_d, mem_we_d;
  logic [XLEN-1:0] wb_data_d, mem_addr_d, mem_wdata_d;
  logic [4:0]      rd_out_d;
  logic [3:0]      mem_wstrb_d;

  logic            mem_op, illegal, misaligned, bad_op, expired;
  logic [XLEN-1:0] steer_data;
  logic [3:0]      steer_strb;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;

  // Operation legality for the instruction presented at the input
  always_comb begin
    mem_op     = is_load | is_store;
    misaligned = ((funct3_in[1:0] == 2'b01) && alu_res[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (alu_res[1:0] != 2'b00));
    if (is_load) begin
      illegal = (funct3_in == 3'b011) || (funct3_in == 3'b110) || (funct3_in == 3'b111);
    end else begin
      illegal = funct3_in[2] || (funct3_in[1:0] == 2'b11);
    end
    bad_op  = illegal | misaligned;
    expired = (timer_q == TW'(TIMEOUT - 1));
  end

  // Store lane steering: narrow data is replicated, strobes select the lanes
  always_comb begin
    steer_data = store_data;
    steer_strb = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        steer_data = {4{store_data[7:0]}};
        steer_strb = 4'b0001 << alu_res[1:0];
      end
      2'b01: begin
        steer_data = {2{store_data[15:0]}};
        steer_strb = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        steer_data = store_data;
        steer_strb = 4'b1111;
      end
    endcase
  end

  // Load extraction from the lanes latched at accept
  always_comb begin
    byte_sel = 8'(mem_rdata >> {lane_q, 3'b000});
    half_sel = 16'(mem_rdata >> {lane_q[1], 4'b0000});
    case (f3_q[1:0])
      2'b00:   load_val = f3_q[2] ? XLEN'(byte_sel) : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      2'b01:   load_val = f3_q[2] ? XLEN'(half_sel) : {{(XLEN-16){half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (mem_op && !bad_op) ? BUS : DONE;
        end
      end
      BUS: begin
        if (mem_ack || expired) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and transaction context
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    mem_req_d   = (state_d == BUS);
    wb_data_d   = wb_data;
    rd_out_d    = rd_out;
    reg_write_d = reg_write;
    out_err_d   = out_err;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    timer_d     = timer_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    ld_d        = ld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_out_d    = rd_in;
          wb_data_d   = '0;
          reg_write_d = 1'b0;
          out_err_d   = 1'b0;
          if (!mem_op) begin
            wb_data_d   = alu_res;
            reg_write_d = 1'b1;
          end else if (bad_op) begin
            out_err_d = 1'b1;
          end else begin
            mem_we_d    = ~is_load;
            mem_addr_d  = {alu_res[XLEN-1:2], 2'b00};
            mem_wdata_d = is_load ? '0 : steer_data;
            mem_wstrb_d = is_load ? 4'b0000 : steer_strb;
            f3_d        = funct3_in;
            lane_d      = alu_res[1:0];
            ld_d        = is_load;
            timer_d     = '0;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          if (ld_q) begin
            wb_data_d   = load_val;
            reg_write_d = 1'b1;
          end
        end else if (expired) begin
          out_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        // Bus fields return to idle once the transaction ends
        if (state_d != BUS) begin
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_wstrb_d = 4'b0000;
          timer_d     = '0;
        end
      end
      default: ;
    endcase
  end

  // Output and context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      wb_data   <= '0;
      rd_out    <= '0;
      reg_write <= 1'b0;
      out_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      timer_q   <= '0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      ld_q      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      wb_data   <= wb_data_d;
      rd_out    <= rd_out_d;
      reg_write <= reg_write_d;
      out_err   <= out_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      timer_q   <= timer_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      ld_q      <= ld_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_res, store_data;
  logic [2:0]  funct3_in;
  logic        is_load, is_store;
  logic [4:0]  rd_in, rd_out;
  logic        out_valid, reg_write, out_err;
  logic [31:0] wb_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .store_data(store_data), .funct3_in(funct3_in),
    .is_load(is_load), .is_store(is_store), .rd_in(rd_in),
    .out_valid(out_valid), .wb_data(wb_data), .rd_out(rd_out),
    .reg_write(reg_write), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: whole-transaction outcome from the operation, address and bus behaviour
  task automatic model(input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input logic [2:0] f3, input bit ld, input bit st, input int w,
                       output bit e_err, output bit e_rw, output logic [31:0] e_wb,
                       output logic [31:0] e_wdata, output logic [3:0] e_strb,
                       output int e_req, output int e_lat);
    int nb, off;
    longint unsigned v, mask;
    bit bad;
    nb  = 1 << f3[1:0];
    off = int'(a[1:0]);
    bad = ld ? (f3 == 3'd3 || f3 >= 3'd6) : (f3 > 3'd2);
    if ((nb == 2 && (off % 2) != 0) || (nb == 4 && off != 0)) bad = 1'b1;
    e_strb  = st ? 4'(((1 << nb) - 1) << off) : 4'd0;
    e_wdata = (nb == 1) ? sd[7:0] * 32'h0101_0101 :
              (nb == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    v    = longint'(rdata) >> (8 * off);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    if (!(ld || st)) begin
      e_err = 0; e_rw = 1; e_wb = a; e_req = 0; e_lat = 1;
    end else if (bad) begin
      e_err = 1; e_rw = 0; e_wb = 0; e_req = 0; e_lat = 1;
    end else if (w >= int'(TO)) begin
      e_err = 1; e_rw = 0; e_wb = 0; e_req = int'(TO); e_lat = int'(TO) + 1;
    end else begin
      e_err = 0; e_rw = ld; e_wb = ld ? v[31:0] : 32'd0; e_req = w + 1; e_lat = w + 2;
    end
  endtask

  // Issue one instruction, act as the memory (ack after w wait cycles), check the result
  task automatic txn(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                     input bit ld, input bit st, input logic [4:0] rd, input int w,
                     input logic [31:0] rdata);
    bit e_err, e_rw, done;
    logic [31:0] e_wb, e_wdata;
    logic [3:0] e_strb;
    int e_req, e_lat, req_n;
    model(a, sd, rdata, f3, ld, st, w, e_err, e_rw, e_wb, e_wdata, e_strb, e_req, e_lat);
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    alu_res = a; store_data = sd; funct3_in = f3; is_load = ld; is_store = st; rd_in = rd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_res = $urandom; store_data = $urandom; rd_in = 5'($urandom);
    req_n = 0;
    done  = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (mem_req) begin
        req_n++;
        chk("mem_we", 32'(mem_we), 32'(st));
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
        if (st) chk("mem_wdata", mem_wdata, e_wdata);
        mem_ack   = (req_n == w + 1);
        mem_rdata = mem_ack ? rdata : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
      if (out_valid) begin
        chk("latency", 32'(cyc), 32'(e_lat));
        chk("req_cycles", 32'(req_n), 32'(e_req));
        chk("wb_data", wb_data, e_wb);
        chk("reg_write", 32'(reg_write), 32'(e_rw));
        chk("out_err", 32'(out_err), 32'(e_err));
        chk("rd_out", 32'(rd_out), 32'(rd));
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) chk("out_valid_seen", 32'd0, 32'd1);
    // A stray ack after completion must be ignored
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("out_valid_pulse", 32'(out_valid), 32'd0);
    chk("mem_req_idle", 32'(mem_req), 32'd0);
    chk("in_ready_post", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit st, ld;
    int kind, w;
    rst = 1'b0; in_valid = 1'b0; alu_res = '0; store_data = '0; funct3_in = '0;
    is_load = 1'b0; is_store = 1'b0; rd_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    txn(32'h1234_5678, 32'h0, 3'b010, 0, 0, 5'd7, 0, 32'h0);
    txn(32'h0000_0103, 32'h0, 3'b000, 1, 0, 5'd3, 2, 32'h80FF_0011);
    txn(32'h0000_0103, 32'h0, 3'b100, 1, 0, 5'd4, 2, 32'h80FF_0011);
    txn(32'h0000_2002, 32'hAAAA_BEEF, 3'b001, 0, 1, 5'd5, 0, 32'h0);
    txn(32'h0000_0101, 32'h0, 3'b010, 1, 0, 5'd6, 0, 32'h0);
    txn(32'h0000_0200, 32'h0, 3'b010, 1, 0, 5'd8, 100, 32'hDEAD_BEEF);
    txn(32'h0000_0300, 32'h5, 3'b100, 0, 1, 5'd9, 0, 32'h0);
    txn(32'h0000_0402, 32'h0, 3'b101, 1, 0, 5'd10, 1, 32'h9ABC_1234);

    // Reset while a request is outstanding
    alu_res = 32'h40; funct3_in = 3'b010; is_load = 1; is_store = 0; rd_in = 5'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    txn(32'h0000_0044, 32'h0, 3'b010, 1, 0, 5'd11, 1, 32'h0BAD_F00D);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      ld = (kind == 1);
      st = (kind == 2);
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      txn($urandom, $urandom, 3'($urandom), ld, st, 5'($urandom), w, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
